pipe_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32 pipeline. Generates every hold, bubble and flush control for the PC, F/D and D/E registers from E-stage and M-stage status. Also sequences the multi-cycle mul/div in E and the data-memory wait in M. Its outputs drive the D/E register's `stall` (bubble insert) and `jb` (flush) inputs directly.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32 5-stage hazard/sequencing controller; PIPE_HAZARD_CTRL_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] D_rs1_index,
    input  logic [4:0] D_rs2_index,
    input  logic       D_rs1_used,
    input  logic       D_rs2_used,
    input  logic [4:0] E_rd_index,
    input  logic       E_is_load,
    input  logic       E_is_muldiv,
    input  logic       jb,
    input  logic       M_mem_req,
    input  logic       M_mem_ready,
    output logic       pc_hold,
    output logic       D_hold,
    output logic       D_flush,
    output logic       E_stall,
    output logic       E_jb,
    output logic       E_hold,
    output logic       M_bubble,
    output logic       pipe_freeze,
    output logic       md_start
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , output logic [CNT_W-1:0] stall_cycles
    , output logic [CNT_W-1:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_eval_state;
    logic [3:0] r_md_cnt;
    logic [3:0] w_md_cnt_next;
    logic       w_mem_wait;
    logic       w_load_use;

    assign w_mem_wait = (r_state == ST_MEM_WAIT) ? ~M_mem_ready : (M_mem_req & ~M_mem_ready);

    // The cycle that releases a memory wait resumes whatever the freeze interrupted.
    assign w_eval_state = (r_state != ST_MEM_WAIT) ? r_state :
                          ((r_md_cnt != 4'd0) ? ST_MD_BUSY : ST_RUN);

    assign w_load_use = E_is_load && (E_rd_index != 5'd0) &&
                        ((D_rs1_used && (D_rs1_index == E_rd_index)) ||
                         (D_rs2_used && (D_rs2_index == E_rd_index)));

    always_comb begin
        pc_hold       = 1'b0;
        D_hold        = 1'b0;
        D_flush       = 1'b0;
        E_stall       = 1'b0;
        E_jb          = 1'b0;
        E_hold        = 1'b0;
        M_bubble      = 1'b0;
        pipe_freeze   = 1'b0;
        md_start      = 1'b0;
        w_next_state  = r_state;
        w_md_cnt_next = r_md_cnt;
        if (rst) begin
            w_next_state  = ST_RUN;
            w_md_cnt_next = 4'd0;
        end else if (w_mem_wait) begin
            pc_hold      = 1'b1;
            D_hold       = 1'b1;
            E_hold       = 1'b1;
            pipe_freeze  = 1'b1;
            w_next_state = ST_MEM_WAIT;
        end else if (w_eval_state == ST_MD_BUSY) begin
            if (r_md_cnt > 4'd1) begin
                pc_hold       = 1'b1;
                D_hold        = 1'b1;
                E_hold        = 1'b1;
                M_bubble      = 1'b1;
                w_md_cnt_next = r_md_cnt - 4'd1;
                w_next_state  = ST_MD_BUSY;
            end else begin
                w_md_cnt_next = 4'd0;
                w_next_state  = ST_RUN;
            end
        end else begin
            w_next_state = ST_RUN;
            if (E_is_muldiv) begin
                md_start      = 1'b1;
                pc_hold       = 1'b1;
                D_hold        = 1'b1;
                E_hold        = 1'b1;
                M_bubble      = 1'b1;
                w_md_cnt_next = 4'(MD_LATENCY - 1);
                w_next_state  = ST_MD_BUSY;
            end else if (jb) begin
                D_flush = 1'b1;
                E_jb    = 1'b1;
            end else if (w_load_use) begin
                pc_hold = 1'b1;
                D_hold  = 1'b1;
                E_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_md_cnt_next;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Saturating so a long run never wraps back to a misleadingly small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (pc_hold && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (E_jb && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
